qadd_pipe: RTL
==============

QADD_PIPE -- requirements
Module: qadd_pipe

Interface
REQ-001 The block SHALL have parameter Q, default 15, giving the number of fractional bits (documentation only; arithmetic is independent of Q).
REQ-002 The block SHALL have parameter N, default 32, giving the total word width: bit N-1 is the sign and bits N-2:0 are the magnitude (sign-magnitude format).
REQ-003 The block SHALL have parameter SAT, default 1: 1 saturates on overflow, 0 wraps.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  an operation is presented.
REQ-007 in_ready  output  1  the block can accept an operation this cycle.
REQ-008 op  input  2  operation select: 00 ADD, 01 SUB, 10 ACC, 11 LOAD.
REQ-009 a  input  N  first operand, sign-magnitude.
REQ-010 b  input  N  second operand, sign-magnitude; ignored for ACC and LOAD.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 c  output  N  result, sign-magnitude.
REQ-014 ovf  output  1  magnitude overflow occurred for the result currently on c.

Function
REQ-015 A transfer SHALL occur on any edge where valid and ready are both high; c and ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-016 Pipeline SHALL have two register stages: S1 captures op/a/b; S2 performs the arithmetic and drives c/ovf/out_valid.
REQ-017 Latency SHALL be 2 edges from the input transfer edge to out_valid=1 with that result.
REQ-018 Throughput SHALL be one operation per cycle when out_ready=1.
REQ-019 S2 SHALL advance when S2 is empty or out_ready=1.
REQ-020 in_ready SHALL equal (S1 empty) OR (S2 advancing); it SHALL NOT depend on in_valid or op.
REQ-021 ADD SHALL give c=a+b; SUB SHALL give c=a+(b with its sign inverted).
REQ-022 ACC SHALL give acc_next=acc+a and c=acc_next; LOAD SHALL give acc_next=a and c=a with ovf=0; ADD and SUB SHALL NOT modify acc.
REQ-023 acc SHALL be read and written only in S2, in transfer order, so back-to-back ACC/LOAD operations need no stall.
REQ-024 Same-sign operands: magnitudes SHALL be added at N bits, and the result SHALL take the common sign.
REQ-025 Opposite-sign operands: the smaller magnitude SHALL be subtracted from the larger, and the result SHALL take the sign of the larger magnitude.
REQ-026 Equal magnitudes with opposite signs SHALL give +0.
REQ-027 An input negative zero (sign=1, magnitude=0) SHALL be treated as +0.
REQ-028 No output, and no acc value, SHALL ever be negative zero.
REQ-029 Overflow is a carry out of bit N-2 of the magnitude sum; on overflow ovf SHALL be 1.
REQ-030 On overflow with SAT=1, the magnitude SHALL be all ones and the sign kept; with SAT=0, the low N-1 bits SHALL be kept. ACC SHALL store the same value in acc.
REQ-031 Simultaneous input transfer and output transfer on a full pipe SHALL lose and duplicate nothing.

Reset
REQ-032 While rst=1: S1 and S2 valid bits=0, out_valid=0, in_ready=0, c=0, ovf=0, acc=0.
REQ-033 in_ready SHALL return to 1 on the first edge after rst falls.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight operations; no result SHALL appear after reset for operations accepted before it.

Structure
REQ-035 A shared package qadd_pkg SHALL hold the op encodings (OP_ADD, OP_SUB, OP_ACC, OP_LOAD).
REQ-036 A combinational sub-module sm_addsub (N, SAT) SHALL implement REQ-024 to REQ-030 and be instantiated once, in S2.

Verification (N=32, Q=15)
REQ-037 ADD a=0x00008000, b=0x80004000 -> c=0x00004000, ovf=0, two edges after acceptance.
REQ-038 SUB a=0x00004000, b=0x00004000 -> c=0x00000000; separately, ADD a=0x80000000, b=0x80000000 -> c=0x00000000.
REQ-039 ADD a=0x7FFFFFFF, b=0x00000001: SAT=1 -> c=0x7FFFFFFF, ovf=1; SAT=0 -> c=0x00000000, ovf=1.
REQ-040 Back-to-back LOAD 0x00008000, ACC 0x00008000, ACC 0x80018000 -> c sequence 0x00008000, 0x00010000, 0x80008000.
REQ-041 Stream 4 ADDs with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted, c held stable; release out_ready -> all 4 results appear in order, with none lost or duplicated.
REQ-042 Assert rst with 2 operations in flight -> out_valid=0 at once; after release, ACC 0x00008000 -> c=0x00008000.

Source files
------------

// File: rtl/qadd_pkg.sv
// Shared definitions for the sign-magnitude add/accumulate pipeline.
package qadd_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

endpackage

// File: rtl/sm_addsub.sv
// Combinational sign-magnitude adder with optional saturation.
// Never produces negative zero; treats a negative-zero input as +0.
module sm_addsub #(
  parameter int unsigned N   = 32,
  parameter int unsigned SAT = 1
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_c,
  output logic         o_ovf
);

  localparam int unsigned MW = N - 1;

  logic [MW-1:0] w_ma;
  logic [MW-1:0] w_mb;
  logic [MW-1:0] w_mag;
  logic          w_sa;
  logic          w_sb;
  logic          w_sign;
  logic [N-1:0]  w_sum;

  assign w_ma  = i_a[MW-1:0];
  assign w_mb  = i_b[MW-1:0];
  // A zero magnitude is positive regardless of its sign bit.
  assign w_sa  = i_a[N-1] & (|w_ma);
  assign w_sb  = i_b[N-1] & (|w_mb);
  assign w_sum = {1'b0, w_ma} + {1'b0, w_mb};

  always_comb begin
    w_mag  = '0;
    w_sign = 1'b0;
    o_ovf  = 1'b0;
    if (w_sa == w_sb) begin
      o_ovf  = w_sum[N-1];
      w_sign = w_sa;
      if (w_sum[N-1] && (SAT != 0)) begin
        w_mag = '1;
      end else begin
        w_mag = w_sum[MW-1:0];
      end
    end else if (w_ma >= w_mb) begin
      w_mag  = w_ma - w_mb;
      w_sign = w_sa;
    end else begin
      w_mag  = w_mb - w_ma;
      w_sign = w_sb;
    end
  end

  assign o_c = {w_sign & (|w_mag), w_mag};

endmodule

// File: rtl/qadd_pipe.sv
// Two-stage valid/ready sign-magnitude ADD/SUB/ACC/LOAD pipeline.
// S1 holds the operation; S2 does the arithmetic and owns the accumulator.
module qadd_pipe
  import qadd_pkg::*;
#(
  parameter int unsigned Q   = 15,
  parameter int unsigned N   = 32,
  parameter int unsigned SAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  if (Q >= N) begin : g_bad_q
    $error("qadd_pipe: Q must be smaller than N");
  end

  logic         r_rdy_en;
  logic         r_s1_valid;
  op_e          r_s1_op;
  logic [N-1:0] r_s1_a;
  logic [N-1:0] r_s1_b;
  logic         r_s2_valid;
  logic [N-1:0] r_c;
  logic         r_ovf;
  logic [N-1:0] r_acc;

  logic         w_s2_adv;
  logic [N-1:0] w_opa;
  logic [N-1:0] w_opb;
  logic [N-1:0] w_sum;
  logic         w_sum_ovf;
  logic [N-1:0] w_load;

  assign w_s2_adv  = ~r_s2_valid | out_ready;
  // r_rdy_en keeps in_ready low until the first edge after reset releases.
  assign in_ready  = r_rdy_en & (~r_s1_valid | w_s2_adv);
  assign out_valid = r_s2_valid;
  assign c         = r_c;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_en   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_op <= op_e'(op);
          r_s1_a  <= a;
          r_s1_b  <= b;
        end
      end
    end
  end

  // Operand steering into the single shared adder.
  always_comb begin
    w_opa = r_s1_a;
    w_opb = r_s1_b;
    unique case (r_s1_op)
      OP_SUB: w_opb = {~r_s1_b[N-1], r_s1_b[N-2:0]};
      OP_ACC: begin
        w_opa = r_acc;
        w_opb = r_s1_a;
      end
      default: ;
    endcase
  end

  assign w_load = (|r_s1_a[N-2:0]) ? r_s1_a : '0;

  sm_addsub #(
    .N   (N),
    .SAT (SAT)
  ) u_addsub (
    .i_a   (w_opa),
    .i_b   (w_opb),
    .o_c   (w_sum),
    .o_ovf (w_sum_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_c        <= '0;
      r_ovf      <= 1'b0;
      r_acc      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        unique case (r_s1_op)
          OP_LOAD: begin
            r_c   <= w_load;
            r_ovf <= 1'b0;
            r_acc <= w_load;
          end
          OP_ACC: begin
            r_c   <= w_sum;
            r_ovf <= w_sum_ovf;
            r_acc <= w_sum;
          end
          default: begin
            r_c   <= w_sum;
            r_ovf <= w_sum_ovf;
          end
        endcase
      end
    end
  end

endmodule
